leaf_spine_uplink: RTL and testbench

//  Leaf-side injection stage that feeds the four spine-router leaf ports (spineX1..spineX4 _in_data/_in_valid).

---
 rtl/noc_pkg.sv | 23 ++
 rtl/noc_sync_fifo.sv | 54 +++++
 rtl/leaf_spine_uplink.sv | 143 ++++++++++++++
 tb/tb_leaf_spine_uplink.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, ID widths and uplink FSM encodings.
package noc_pkg;

  localparam int FLIT_W      = 16;
  localparam int GRP_ID_W    = 4;
  localparam int LEAF_ID_W   = 2;
  localparam int DEST_NODE_W = 2;
  localparam int PAYLOAD_W   = 8;

  // Flit layout, MSB first: [15:12] dest group, [11:10] dest leaf,
  // [9:8] dest node, [7:0] payload.
  typedef struct packed {
    logic [GRP_ID_W-1:0]    dest_grp;
    logic [LEAF_ID_W-1:0]   dest_leaf;
    logic [DEST_NODE_W-1:0] dest_node;
    logic [PAYLOAD_W-1:0]   payload;
  } flit_t;

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_SEND        = 2'd1;
  localparam logic [1:0] ST_WAIT_CREDIT = 2'd2;

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head. A push while full is
// dropped even if a pop happens in the same cycle.
module noc_sync_fifo #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DWIDTH-1:0] din,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic              one_left,
  output logic [DWIDTH-1:0] head
);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = AW + 1;

  logic [DEPTH-1:0][DWIDTH-1:0] mem;
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic [CNTW-1:0]              count;
  logic                         do_push, do_pop;

  assign full     = (count == CNTW'(DEPTH));
  assign empty    = (count == '0);
  assign one_left = (count == CNTW'(1));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head     = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/leaf_spine_uplink.sv
// Leaf injection stage: buffers node flits, loops back same-leaf traffic and
// sprays the rest round-robin over credit-gated spine uplinks.
module leaf_spine_uplink
  import noc_pkg::*;
#(
  parameter logic [GRP_ID_W-1:0]  GROUP_ID   = 4'b1000,
  parameter logic [LEAF_ID_W-1:0] LEAF_ID    = 2'd0,
  parameter int                   DWIDTH     = 16,
  parameter int                   FIFO_DEPTH = 8,
  parameter int                   NUM_SPINES = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DWIDTH-1:0]              node_in_data,
  input  logic                           node_in_valid,
  output logic                           node_in_ready,
  output logic [NUM_SPINES*DWIDTH-1:0]   spine_out_data,
  output logic [NUM_SPINES-1:0]          spine_out_valid,
  input  logic [NUM_SPINES-1:0]          spine_credit_return,
  output logic [DWIDTH-1:0]              local_out_data,
  output logic                           local_out_valid,
  output logic [15:0]                    stall_cnt,
  output logic                           credit_err
);
  localparam int             CW   = $clog2(FIFO_DEPTH + 1);
  localparam int             SW   = (NUM_SPINES > 1) ? $clog2(NUM_SPINES) : 1;
  localparam logic [CW-1:0]  CMAX = CW'(FIFO_DEPTH);

  logic                          fifo_full, fifo_empty, fifo_one, fifo_pop;
  logic [DWIDTH-1:0]             head;
  flit_t                         head_f;
  logic [NUM_SPINES-1:0][CW-1:0] credit;
  logic [SW-1:0]                 rr_ptr, sel, idx;
  logic                          sel_ok;
  logic                          head_local, disp_local, disp_spine, blocked, push_acc;
  logic [NUM_SPINES-1:0]         disp_vec;
  logic [1:0]                    state, state_nxt;

  noc_sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (node_in_valid),
    .din      (node_in_data),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .one_left (fifo_one),
    .head     (head)
  );

  assign node_in_ready = !fifo_full;
  assign push_acc      = node_in_valid && !fifo_full;
  assign head_f        = head;
  assign head_local    = !fifo_empty && (head_f.dest_grp == GROUP_ID) &&
                         (head_f.dest_leaf == LEAF_ID);

  // Round-robin pick: first spine with credit, scanning from rr_ptr.
  always_comb begin
    sel    = '0;
    sel_ok = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_SPINES; k++) begin
      idx = SW'((int'(rr_ptr) + k) % NUM_SPINES);
      if (!sel_ok && credit[idx] != '0) begin
        sel_ok = 1'b1;
        sel    = idx;
      end
    end
  end

  assign disp_local = head_local;
  assign disp_spine = !fifo_empty && !head_local && sel_ok;
  assign blocked    = !fifo_empty && !head_local && !sel_ok;
  assign fifo_pop   = disp_local || disp_spine;
  assign disp_vec   = disp_spine ? (NUM_SPINES'(1) << sel) : '0;

  // Per-spine credit counters; a return and a dispatch together cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPINES; i++) credit[i] <= CMAX;
      credit_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SPINES; i++) begin
        case ({spine_credit_return[i], disp_vec[i]})
          2'b01: credit[i] <= credit[i] - 1'b1;
          2'b10: begin
            if (credit[i] == CMAX) credit_err <= 1'b1;
            else                   credit[i]  <= credit[i] + 1'b1;
          end
          default: credit[i] <= credit[i];
        endcase
      end
    end
  end

  // Round-robin pointer advances past the spine just used.
  always_ff @(posedge clk) begin
    if (reset)           rr_ptr <= '0;
    else if (disp_spine) rr_ptr <= SW'((int'(sel) + 1) % NUM_SPINES);
  end

  // Registered output pulses; data slices hold between flits.
  always_ff @(posedge clk) begin
    if (reset) begin
      spine_out_valid <= '0;
      spine_out_data  <= '0;
      local_out_valid <= 1'b0;
      local_out_data  <= '0;
    end else begin
      spine_out_valid <= disp_vec;
      local_out_valid <= disp_local;
      if (disp_local) local_out_data <= head_f;
      for (int i = 0; i < NUM_SPINES; i++)
        if (disp_vec[i]) spine_out_data[i*DWIDTH +: DWIDTH] <= head_f;
    end
  end

  // Next-state logic for the dispatch FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!fifo_empty) state_nxt = ST_SEND;
      ST_SEND: begin
        if (blocked && !(|spine_credit_return))                 state_nxt = ST_WAIT_CREDIT;
        else if (fifo_empty || (fifo_pop && fifo_one && !push_acc)) state_nxt = ST_IDLE;
      end
      ST_WAIT_CREDIT: if ((|spine_credit_return) || !blocked) state_nxt = ST_SEND;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_WAIT_CREDIT && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_leaf_spine_uplink.sv
// Directed bench for leaf_spine_uplink: dispatch, round-robin, credits,
// loopback, error flag and mid-flight reset.
module tb_leaf_spine_uplink;
  import noc_pkg::*;

  localparam int DW = 16;
  localparam int NS = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [DW-1:0]    node_in_data = '0;
  logic             node_in_valid = 1'b0;
  logic             node_in_ready;
  logic [NS*DW-1:0] spine_out_data;
  logic [NS-1:0]    spine_out_valid;
  logic [NS-1:0]    spine_credit_return = '0;
  logic [DW-1:0]    local_out_data;
  logic             local_out_valid;
  logic [15:0]      stall_cnt;
  logic             credit_err;

  int checks = 0;
  int failures = 0;

  leaf_spine_uplink dut (
    .clk                 (clk),
    .reset               (reset),
    .node_in_data        (node_in_data),
    .node_in_valid       (node_in_valid),
    .node_in_ready       (node_in_ready),
    .spine_out_data      (spine_out_data),
    .spine_out_valid     (spine_out_valid),
    .spine_credit_return (spine_credit_return),
    .local_out_data      (local_out_data),
    .local_out_valid     (local_out_valid),
    .stall_cnt           (stall_cnt),
    .credit_err          (credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    node_in_valid = 1'b0;
    spine_credit_return = '0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  function automatic logic [DW-1:0] slice(input int i);
    return spine_out_data[i*DW +: DW];
  endfunction

  // Push 32 spine flits back-to-back and let them drain: all credits end at 0.
  task automatic fill_drain;
    for (int i = 0; i < 32; i++) begin
      node_in_valid = 1'b1;
      node_in_data  = 16'h3000 | 16'(i);
      tick;
    end
    node_in_valid = 1'b0;
    tick;
    tick;
    tick;
  endtask

  initial begin
    int acc, pulses, multi;
    logic [15:0] s0;

    // 1: reset values, single spine flit latency
    do_reset;
    chk("rst_spine_valid", spine_out_valid, 0);
    chk("rst_spine_data0", spine_out_data == '0, 1);
    chk("rst_local_valid", local_out_valid, 0);
    chk("rst_ready", node_in_ready, 1);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_err", credit_err, 0);
    node_in_valid = 1'b1;
    node_in_data  = 16'h3A55;
    tick;
    node_in_valid = 1'b0;
    chk("t1_n1_valid", spine_out_valid, 0);
    tick;
    chk("t1_n2_valid", spine_out_valid, 4'b0001);
    chk("t1_n2_data", slice(0), 16'h3A55);
    chk("t1_credit0", dut.credit[0], 7);
    tick;
    chk("t1_pulse_end", spine_out_valid, 0);

    // 2: round-robin over four spines
    do_reset;
    for (int i = 0; i < 4; i++) begin
      node_in_valid = 1'b1;
      node_in_data  = 16'h3001 + 16'(i);
      tick;
      if (i > 0) chk("t2_rr", spine_out_valid, 32'(1 << (i - 1)));
    end
    node_in_valid = 1'b0;
    tick;
    chk("t2_rr_last", spine_out_valid, 4'b1000);
    chk("t2_data3", slice(3), 16'h3004);
    chk("t2_rr_wrap", dut.rr_ptr, 0);

    // 3: credit exhaustion, stall, credit return
    do_reset;
    acc = 0; pulses = 0; multi = 0;
    node_in_valid = 1'b1;
    for (int i = 0; i < 46; i++) begin
      node_in_data = 16'h3000 | 16'(acc);
      if (node_in_ready) acc++;
      tick;
      if (spine_out_valid != '0) pulses++;
      if ($countones(spine_out_valid) > 1) multi++;
    end
    node_in_valid = 1'b0;
    chk("t3_accepted", acc, 40);
    chk("t3_pulses", pulses, 32);
    chk("t3_onehot", multi, 0);
    chk("t3_ready_full", node_in_ready, 0);
    chk("t3_state_wait", dut.state, ST_WAIT_CREDIT);
    s0 = stall_cnt;
    chk("t3_stall_nz", s0 != 16'h0, 1);
    tick; tick; tick;
    chk("t3_stall_rise", stall_cnt, s0 + 16'd3);
    spine_credit_return = 4'b0100;
    tick;
    spine_credit_return = '0;
    chk("t3_ret_cycle", spine_out_valid, 0);
    tick;
    chk("t3_ret_disp", spine_out_valid, 4'b0100);
    chk("t3_ret_data", slice(2), 16'h3020);
    chk("t3_ready_back", node_in_ready, 1);

    // 4: loopback flit while all spine credits are zero
    do_reset;
    fill_drain;
    node_in_valid = 1'b1;
    node_in_data  = 16'h8000;
    tick;
    node_in_valid = 1'b0;
    chk("t4_n1_local", local_out_valid, 0);
    tick;
    chk("t4_local_valid", local_out_valid, 1);
    chk("t4_local_data", local_out_data, 16'h8000);
    chk("t4_spine_quiet", spine_out_valid, 0);
    tick;
    chk("t4_local_end", local_out_valid, 0);
    chk("t4_stall_zero", stall_cnt, 0);
    chk("t4_state_idle", dut.state, ST_IDLE);

    // 5: overflow return and same-cycle dispatch+return
    do_reset;
    spine_credit_return = 4'b0001;
    tick;
    spine_credit_return = '0;
    chk("t5_err_set", credit_err, 1);
    chk("t5_credit0_hold", dut.credit[0], 8);
    tick; tick; tick;
    chk("t5_err_sticky", credit_err, 1);
    node_in_valid = 1'b1;
    node_in_data  = 16'h3111;
    tick;
    node_in_data  = 16'h3222;
    tick;
    node_in_valid = 1'b0;
    chk("t5_disp0", spine_out_valid, 4'b0001);
    spine_credit_return = 4'b0010;
    tick;
    spine_credit_return = '0;
    chk("t5_disp1", spine_out_valid, 4'b0010);
    chk("t5_data1", slice(1), 16'h3222);
    chk("t5_credit1_net", dut.credit[1], 8);
    chk("t5_credit0", dut.credit[0], 7);

    // 6: reset with buffered flits and a pulse due
    do_reset;
    fill_drain;
    for (int i = 0; i < 5; i++) begin
      node_in_valid = 1'b1;
      node_in_data  = 16'h3100 + 16'(i);
      tick;
    end
    node_in_valid = 1'b0;
    tick;
    tick;
    spine_credit_return = 4'b0001;
    tick;
    spine_credit_return = '0;
    reset = 1'b1;
    tick;
    chk("t6_valid_clr", spine_out_valid, 0);
    chk("t6_local_clr", local_out_valid, 0);
    chk("t6_ready", node_in_ready, 1);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (spine_out_valid != '0 || local_out_valid) pulses++;
    end
    chk("t6_no_stale", pulses, 0);
    chk("t6_stall_clr", stall_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
